// File: rtl/prod_accum_pkg.sv
// prod_accum_pkg: shared types and helpers for the product accumulator stage.
// Holds the FSM state encoding, signed saturation bounds and the sample
// counter width helper.
package prod_accum_pkg;

    // FSM encoding; busy is simply "state is not IDLE".
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Largest positive two's-complement value of a w-bit word (w <= 64).
    function automatic logic [63:0] sat_max(input int unsigned w);
        sat_max = (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of a w-bit word, as a w-bit pattern.
    function automatic logic [63:0] sat_min(input int unsigned w);
        sat_min = 64'd1 << (w - 1);
    endfunction

    // Bits needed to hold a sample count in the range 0..count.
    function automatic int cnt_width(input int count);
        cnt_width = (count < 1) ? 1 : $clog2(count + 1);
    endfunction

endpackage

// File: rtl/prod_accum_stage_sat_add.sv
// sat_add: adds a sign-extended sample to the accumulator one bit wider than
// the accumulator, reports signed overflow and produces the value to store.
// Build option PROD_ACCUM_SAT_EN: when defined, an overflowing sum clamps to
// the signed max/min instead of wrapping.
module sat_add
    import prod_accum_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int ACCWIDTH  = 24
) (
    input  logic [ACCWIDTH-1:0]  acc,
    input  logic [DATAWIDTH-1:0] din,
    output logic [ACCWIDTH-1:0]  res,
    output logic                 ovf_step
);

    logic [ACCWIDTH:0] acc_ext;
    logic [ACCWIDTH:0] din_ext;
    logic [ACCWIDTH:0] sum;

    // Widen both operands by sign extension so the true sum always fits.
    always_comb begin
        acc_ext  = {acc[ACCWIDTH-1], acc};
        din_ext  = {{(ACCWIDTH + 1 - DATAWIDTH){din[DATAWIDTH-1]}}, din};
        sum      = acc_ext + din_ext;
        // The true sign and the stored sign disagree exactly on overflow.
        ovf_step = sum[ACCWIDTH] ^ sum[ACCWIDTH-1];
    end

`ifdef PROD_ACCUM_SAT_EN
    localparam logic [ACCWIDTH-1:0] SAT_HI = ACCWIDTH'(sat_max(ACCWIDTH));
    localparam logic [ACCWIDTH-1:0] SAT_LO = ACCWIDTH'(sat_min(ACCWIDTH));

    // Clamp toward the sign of the true (wide) sum when it does not fit.
    always_comb begin
        if (ovf_step) begin
            res = sum[ACCWIDTH] ? SAT_LO : SAT_HI;
        end else begin
            res = sum[ACCWIDTH-1:0];
        end
    end
`else
    // Two's-complement wrap: keep the low ACCWIDTH bits.
    always_comb begin
        res = sum[ACCWIDTH-1:0];
    end
`endif

endmodule

// File: rtl/prod_accum_stage.sv
// prod_accum_stage: sums every COUNT signed products into a wider accumulator
// and hands each finished sum (plus a sticky overflow flag) downstream.
// Build option PROD_ACCUM_SAT_EN selects saturating instead of wrapping adds
// (handled inside sat_add).
//
// Handshakes: a transfer happens only on a rising edge where valid and ready
// are both 1. The producer may hold valid high while ready is low; nothing is
// consumed. in_ready depends on state and out_ready only, never on in_valid,
// so a pending result can be taken and a new sample accepted on the same edge.
module prod_accum_stage
    import prod_accum_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int ACCWIDTH  = 24,
    parameter int COUNT     = 4
) (
    input  logic                 Clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACCWIDTH-1:0]  out_data,
    output logic                 out_ovf,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam int               CW   = cnt_width(COUNT);
    localparam logic [CW-1:0]    LAST = CW'(COUNT - 1);

    state_t              state;
    logic [ACCWIDTH-1:0] acc;
    logic [CW-1:0]       cnt;
    logic                ovf;

    logic [ACCWIDTH-1:0] res;
    logic                ovf_step;
    logic                in_accept;

    sat_add #(
        .DATAWIDTH (DATAWIDTH),
        .ACCWIDTH  (ACCWIDTH)
    ) u_sat_add (
        .acc      (acc),
        .din      (in_data),
        .res      (res),
        .ovf_step (ovf_step)
    );

    // Ready unless a result is stuck waiting; a taker this cycle frees the slot.
    always_comb begin
        in_ready  = (state != HOLD) || out_ready;
        in_accept = in_valid && in_ready;
        busy      = (state != IDLE);
        dbg_state = state;
    end

    // Accumulation FSM with registered result outputs.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            unique case (state)
                // IDLE, and HOLD once the result is taken, both start a fresh
                // sum from acc=0; in HOLD an accept already implies out_ready.
                IDLE, HOLD: begin
                    if ((state == HOLD) && out_ready && !in_accept) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end else if (in_accept) begin
                        if (COUNT == 1) begin
                            out_data  <= res;
                            out_ovf   <= ovf | ovf_step;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            acc       <= res;
                            cnt       <= CW'(1);
                            ovf       <= ovf_step;
                            out_valid <= 1'b0;
                            state     <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_accept) begin
                        if (cnt == LAST) begin
                            out_data  <= res;
                            out_ovf   <= ovf | ovf_step;
                            out_valid <= 1'b1;
                            acc       <= '0;
                            cnt       <= '0;
                            ovf       <= 1'b0;
                            state     <= HOLD;
                        end else begin
                            acc <= res;
                            cnt <= cnt + CW'(1);
                            ovf <= ovf | ovf_step;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prod_accum_stage.sv
// Directed bench for prod_accum_stage. Three instances cover the default
// configuration (24-bit, COUNT=4), a narrow overflow case (16-bit, COUNT=2)
// and the single-sample case (COUNT=1).
module tb_prod_accum_stage;

    logic Clk;
    logic rst;

    int tests_run    = 0;
    int tests_failed = 0;

    // Instance a: DATAWIDTH=16, ACCWIDTH=24, COUNT=4
    logic        a_in_valid, a_out_ready;
    logic [15:0] a_in_data;
    logic        a_in_ready, a_out_valid, a_out_ovf, a_busy;
    logic [23:0] a_out_data;
    logic [1:0]  a_dbg;

    // Instance b: DATAWIDTH=16, ACCWIDTH=16, COUNT=2
    logic        b_in_valid, b_out_ready;
    logic [15:0] b_in_data;
    logic        b_in_ready, b_out_valid, b_out_ovf, b_busy;
    logic [15:0] b_out_data;
    logic [1:0]  b_dbg;

    // Instance c: DATAWIDTH=16, ACCWIDTH=24, COUNT=1
    logic        c_in_valid, c_out_ready;
    logic [15:0] c_in_data;
    logic        c_in_ready, c_out_valid, c_out_ovf, c_busy;
    logic [23:0] c_out_data;
    logic [1:0]  c_dbg;

    prod_accum_stage #(.DATAWIDTH(16), .ACCWIDTH(24), .COUNT(4)) u_dut_a (
        .Clk(Clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_ovf(a_out_ovf),
        .busy(a_busy), .dbg_state(a_dbg)
    );

    prod_accum_stage #(.DATAWIDTH(16), .ACCWIDTH(16), .COUNT(2)) u_dut_b (
        .Clk(Clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_ovf(b_out_ovf),
        .busy(b_busy), .dbg_state(b_dbg)
    );

    prod_accum_stage #(.DATAWIDTH(16), .ACCWIDTH(24), .COUNT(1)) u_dut_c (
        .Clk(Clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .out_ovf(c_out_ovf),
        .busy(c_busy), .dbg_state(c_dbg)
    );

    // Clock and reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks: present one sample and advance one cycle.
    task automatic drive_a(input logic [15:0] d);
        a_in_valid = 1'b1;
        a_in_data  = d;
        tick();
    endtask

    task automatic drive_b(input logic [15:0] d);
        b_in_valid = 1'b1;
        b_in_data  = d;
        tick();
    endtask

    task automatic drive_c(input logic [15:0] d);
        c_in_valid = 1'b1;
        c_in_data  = d;
        tick();
    endtask

    logic [15:0] exp_ovf_data;

    initial begin
        rst = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_out_data",  {8'd0, a_out_data},   32'd0);
        check("rst_out_ovf",   {31'd0, a_out_ovf},   32'd0);
        check("rst_busy",      {31'd0, a_busy},      32'd0);
        check("rst_state",     {30'd0, a_dbg},       32'd0);
        check("rst_in_ready",  {31'd0, a_in_ready},  32'd1);
        rst = 1'b1;
        tick();

        // 1: basic sum 100 - 20 + 300 + 5 = 385
        a_out_ready = 1'b1;
        drive_a(16'd100);
        check("t1_busy_after_first", {31'd0, a_busy}, 32'd1);
        check("t1_no_early_valid",   {31'd0, a_out_valid}, 32'd0);
        drive_a(16'hFFEC);
        drive_a(16'd300);
        check("t1_no_valid_3", {31'd0, a_out_valid}, 32'd0);
        drive_a(16'd5);
        a_in_valid = 1'b0;
        check("t1_valid",    {31'd0, a_out_valid}, 32'd1);
        check("t1_data",     {8'd0, a_out_data},   32'd385);
        check("t1_ovf",      {31'd0, a_out_ovf},   32'd0);
        tick();
        check("t1_valid_drop", {31'd0, a_out_valid}, 32'd0);
        check("t1_idle",       {31'd0, a_busy},      32'd0);

        // 2: backpressure 1+2+3+4 = 10 held, then back-to-back 50+60+70+80 = 260
        a_out_ready = 1'b0;
        drive_a(16'd1);
        drive_a(16'd2);
        drive_a(16'd3);
        drive_a(16'd4);
        a_in_data = 16'd50;
        check("t2_valid", {31'd0, a_out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("t2_in_ready_low", {31'd0, a_in_ready}, 32'd0);
            check("t2_data_stable",  {8'd0, a_out_data},  32'd10);
            check("t2_valid_held",   {31'd0, a_out_valid}, 32'd1);
            tick();
        end
        a_out_ready = 1'b1;
        #1;
        check("t2_in_ready_comb", {31'd0, a_in_ready}, 32'd1);
        tick();
        check("t2_taken",      {31'd0, a_out_valid}, 32'd0);
        check("t2_accum",      {30'd0, a_dbg},       32'd1);
        drive_a(16'd60);
        drive_a(16'd70);
        drive_a(16'd80);
        a_in_valid = 1'b0;
        check("t2_valid2", {31'd0, a_out_valid}, 32'd1);
        check("t2_data2",  {8'd0, a_out_data},   32'd260);
        tick();
        check("t2_drop2",  {31'd0, a_out_valid}, 32'd0);

        // 3: overflow 0x7FFF + 0x0001 in a 16-bit accumulator
`ifdef PROD_ACCUM_SAT_EN
        exp_ovf_data = 16'h7FFF;
`else
        exp_ovf_data = 16'h8000;
`endif
        b_out_ready = 1'b1;
        drive_b(16'h7FFF);
        drive_b(16'h0001);
        b_in_valid = 1'b0;
        check("t3_valid", {31'd0, b_out_valid}, 32'd1);
        check("t3_data",  {16'd0, b_out_data},  {16'd0, exp_ovf_data});
        check("t3_ovf",   {31'd0, b_out_ovf},   32'd1);
        tick();
        // Overflow must not leak into the next result.
        drive_b(16'd1);
        drive_b(16'd1);
        b_in_valid = 1'b0;
        check("t3_next_data", {16'd0, b_out_data}, 32'd2);
        check("t3_next_ovf",  {31'd0, b_out_ovf},  32'd0);
        tick();

        // 4: COUNT=1 streaming 7, -7, 42 with no idle gaps
        c_out_ready = 1'b1;
        drive_c(16'd7);
        check("t4_v0", {31'd0, c_out_valid}, 32'd1);
        check("t4_d0", {8'd0, c_out_data},   32'd7);
        drive_c(16'hFFF9);
        check("t4_v1", {31'd0, c_out_valid}, 32'd1);
        check("t4_d1", {8'd0, c_out_data},   32'h00FFFFF9);
        drive_c(16'd42);
        c_in_valid = 1'b0;
        check("t4_v2",   {31'd0, c_out_valid}, 32'd1);
        check("t4_d2",   {8'd0, c_out_data},   32'd42);
        check("t4_busy", {31'd0, c_busy},      32'd1);
        tick();
        check("t4_drop", {31'd0, c_out_valid}, 32'd0);
        check("t4_idle", {31'd0, c_busy},      32'd0);

        // 5: reset after 2 of 4 samples, then during a held result
        a_out_ready = 1'b1;
        drive_a(16'd9);
        drive_a(16'd9);
        a_in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("t5_busy_cleared",  {31'd0, a_busy},  32'd0);
        check("t5_state_cleared", {30'd0, a_dbg},   32'd0);
        tick();
        rst = 1'b1;
        a_out_ready = 1'b0;
        drive_a(16'd3);
        drive_a(16'd3);
        drive_a(16'd3);
        drive_a(16'd3);
        a_in_valid = 1'b0;
        check("t5_hold_valid", {31'd0, a_out_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t5_hold_valid_clr", {31'd0, a_out_valid}, 32'd0);
        check("t5_hold_data_clr",  {8'd0, a_out_data},   32'd0);
        tick();
        rst = 1'b1;
        a_out_ready = 1'b1;
        drive_a(16'd1);
        drive_a(16'd1);
        drive_a(16'd1);
        drive_a(16'd1);
        a_in_valid = 1'b0;
        check("t5_after_valid", {31'd0, a_out_valid}, 32'd1);
        check("t5_after_data",  {8'd0, a_out_data},   32'd4);
        tick();

        // 6: gapped input, 10 x4 with in_valid toggling
        for (int i = 0; i < 4; i++) begin
            drive_a(16'd10);
            check("t6_busy", {31'd0, a_busy}, 32'd1);
            if (i < 3) begin
                a_in_valid = 1'b0;
                tick();
                check("t6_busy_gap",  {31'd0, a_busy},      32'd1);
                check("t6_no_valid",  {31'd0, a_out_valid}, 32'd0);
            end
        end
        a_in_valid = 1'b0;
        check("t6_valid", {31'd0, a_out_valid}, 32'd1);
        check("t6_data",  {8'd0, a_out_data},   32'd40);
        tick();
        check("t6_drop",  {31'd0, a_out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
